// File: rtl/cra_share_ctrl.sv
// cra_share_ctrl / cra8bits
//
// Purpose: shares one 8-bit carry-ripple adder between two requesters.
// A W-bit add runs one byte slice per cycle. The carry between slices is
// held in a register. Arbitration is round-robin when both requesters
// are valid.
//
// Ports (cra_share_ctrl):
//   clk, rst_n                 clock; asynchronous reset, active-low
//   req0_valid/ready/a/b/cin   requester 0 valid/ready, operands, carry-in
//   req1_valid/ready/a/b/cin   requester 1, same signals as requester 0
//   rsp_valid/ready            result handshake to the consumer
//   rsp_id                     index of the requester that owns the result
//   rsp_s, rsp_cout            W-bit sum and final carry-out
//
// Ports (cra8bits):
//   a, b, ci  8-bit operands and carry-in
//   s, co     8-bit sum and carry-out

module cra8bits (
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic       ci,
  output logic [7:0] s,
  output logic       co
);
  logic [8:0] c;

  assign c[0] = ci;

  for (genvar i = 0; i < 8; i++) begin : g_fa
    assign s[i]   = a[i] ^ b[i] ^ c[i];
    assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
  end

  assign co = c[8];
endmodule

module cra_share_ctrl #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         req0_valid,
  output logic         req0_ready,
  input  logic [W-1:0] req0_a,
  input  logic [W-1:0] req0_b,
  input  logic         req0_cin,
  input  logic         req1_valid,
  output logic         req1_ready,
  input  logic [W-1:0] req1_a,
  input  logic [W-1:0] req1_b,
  input  logic         req1_cin,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic         rsp_id,
  output logic [W-1:0] rsp_s,
  output logic         rsp_cout
);
  localparam int N  = W / 8;
  localparam int SW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t         state, state_nx;
  logic [W-1:0]   a_q, b_q;
  logic           carry;
  logic           prio;
  logic [SW-1:0]  slice;

  logic           any_valid, grant, hs, last_slice;
  logic [7:0]     sa, sb, ss;
  logic           sco;
  logic [SW+2:0]  shamt;

  // Grant: prio breaks the tie; otherwise the only valid requester wins.
  assign any_valid = req0_valid | req1_valid;
  assign grant     = (req0_valid && req1_valid) ? prio : req1_valid;

  // rst_n gates ready so nothing can be accepted while reset is held.
  assign req0_ready = rst_n && (state == IDLE) && any_valid && !grant;
  assign req1_ready = rst_n && (state == IDLE) && any_valid &&  grant;
  assign hs         = (req0_valid && req0_ready) || (req1_valid && req1_ready);

  // Byte-lane offset of the current slice.
  assign shamt      = {slice, 3'b000};
  assign sa         = 8'(a_q >> shamt);
  assign sb         = 8'(b_q >> shamt);
  assign last_slice = (slice == SW'(N - 1));

  cra8bits u_add (
    .a  (sa),
    .b  (sb),
    .ci (carry),
    .s  (ss),
    .co (sco)
  );

  assign rsp_valid = (state == DONE);

  // Next-state logic.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (hs)         state_nx = RUN;
      RUN:     if (last_slice) state_nx = DONE;
      DONE:    if (rsp_ready)  state_nx = IDLE;
      default:                 state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // Datapath: operand capture at accept, then one slice per RUN cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q      <= '0;
      b_q      <= '0;
      carry    <= 1'b0;
      prio     <= 1'b0;
      slice    <= '0;
      rsp_id   <= 1'b0;
      rsp_s    <= '0;
      rsp_cout <= 1'b0;
    end else begin
      case (state)
        IDLE: if (hs) begin
          a_q    <= grant ? req1_a   : req0_a;
          b_q    <= grant ? req1_b   : req0_b;
          carry  <= grant ? req1_cin : req0_cin;
          rsp_id <= grant;
          prio   <= ~grant;
          slice  <= '0;
        end
        RUN: begin
          // Replace only the byte lane of the current slice.
          rsp_s <= (rsp_s & ~(W'(8'hFF) << shamt)) | (W'(ss) << shamt);
          carry <= sco;
          if (last_slice) begin
            rsp_cout <= sco;
            slice    <= '0;
          end else begin
            slice <= slice + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: doc/cra_share_ctrl.md
# cra_share_ctrl

Multi-cycle sequencer and arbiter that shares one `cra8bits` 8-bit carry-ripple adder between two requesters. It performs W-bit additions one 8-bit slice per cycle, holding the inter-slice carry in a register. It sits between two operand producers and one result consumer, using valid/ready handshakes on all sides.

## Interface
- `W`, default 32. Operand width. Must be a multiple of 8 and at least 8. `N = W/8` slices.
- `clk`  in  1  Sole clock. Rising-edge.
- `rst_n`  in  1  Asynchronous reset, active-low.
- `req0_valid`  in  1  Requester 0 has an operation pending.
- `req0_ready`  out  1  Requester 0 operands are accepted this cycle.
- `req0_a`, `req0_b`  in  W  Requester 0 operands.
- `req0_cin`  in  1  Requester 0 carry-in.
- `req1_valid`, `req1_ready`, `req1_a`, `req1_b`, `req1_cin`: same as requester 0, for requester 1.
- `rsp_valid`  out  1  Result is available.
- `rsp_ready`  in  1  Consumer accepts the result.
- `rsp_id`  out  1  Index of the requester that owns the result.
- `rsp_s`  out  W  Sum.
- `rsp_cout`  out  1  Carry out of the most significant slice.

## Operation
- FSM states: IDLE, RUN, DONE. Reset state is IDLE.
- **IDLE: grant**
  - If both valids are high, grant goes to requester `prio`.
  - If only one valid is high, grant goes to that requester.
  - `reqX_ready = (state==IDLE) && grant==X`. Ready may depend on valid. A requester's valid must not depend on ready.
- **IDLE: accept**
  - On a handshake, register `a`, `b`, `cin` and `id`.
  - Set `slice = 0` and the carry register to `cin`.
  - Set `prio` to the requester that was not granted.
  - Go to RUN.
- **RUN**
  - Each cycle, the single adder instance adds `a[8k+7:8k] + b[8k+7:8k] + carry`, where `k = slice`.
  - The sum is written into `rsp_s[8k+7:8k]`, `carry` takes the slice carry-out, and `slice` increments.
  - After slice `N-1` completes, `rsp_cout` takes the final carry and the FSM goes to DONE.
- **DONE**
  - `rsp_valid = 1`.
  - `rsp_s`, `rsp_cout` and `rsp_id` are held stable until `rsp_valid && rsp_ready`. Then go to IDLE.
  - No request is accepted in RUN or DONE.
- **Arithmetic:** modulo 2^W plus carry-out. `{rsp_cout, rsp_s} = a + b + cin`, exactly W+1 bits.
- **Reset values:**
  - All `req_ready` are 0 while `rst_n` is low. `rsp_valid`, `rsp_s`, `rsp_cout`, `rsp_id` are 0.
  - `prio` is 0, `slice` is 0, `carry` is 0.
- **Reset mid-operation:** the in-flight operation is discarded and no response is produced. After release, the block behaves as freshly reset.
- **Operand changes:** requester operands are sampled only at the accept edge. Later changes do not affect the result.
- **W=8 (N=1):** RUN lasts exactly one cycle.

## Timing
- Cycle 0: IDLE, handshake on edge E0.
- Cycles 1..N: RUN, with slice k computed in cycle k+1.
- Cycle N+1: DONE, `rsp_valid` high. `rsp_valid` rises exactly N cycles after the accept edge.
- With `rsp_ready` held high, DONE lasts 1 cycle and the next accept can happen in cycle N+2. Minimum issue interval is N+2 cycles (6 for W=32).
- Backpressure: DONE persists for any number of cycles with all outputs stable. Both `req_ready` stay 0 during this time.
- `rsp_s` upper slices may show partial values during RUN. They are valid only while `rsp_valid` is high.
- Combinational paths:
  - `req*_valid` → `req*_ready`, through the grant logic only.
  - Operand registers → adder → slice registers.
  - No path from `rsp_ready` to any output in the same cycle, apart from the state update at the next edge.

## Test plan
- **Full carry chain:** W=32, req0 sends `a=0xFFFFFFFF`, `b=0x00000001`, `cin=0`. Required: `rsp_s=0x00000000`, `rsp_cout=1`, `rsp_id=0`, `rsp_valid` rises 4 cycles after accept.
- **Carry-in propagation:** req1 sends `a=0x12345678`, `b=0x0FEDCBA8`, `cin=1`. Required: `rsp_s=0x22222221`, `rsp_cout=0`, `rsp_id=1`.
- **Round-robin arbitration:** both valids held high from reset for 3 operations. Required: grants go 0, 1, 0. The ungranted requester sees `ready=0` until its turn, and its operands are unaffected by the other's operation.
- **Backpressure:** hold `rsp_ready=0` for 5 cycles in DONE. Required: `rsp_valid`, `rsp_s`, `rsp_cout` and `rsp_id` are stable, no `req_ready` is asserted, and IDLE is re-entered on the cycle after `rsp_ready=1`.
- **Reset mid-operation:** assert `rst_n=0` during RUN slice 2. Required: outputs immediately go to reset values, and no `rsp_valid` appears for the aborted operation. A new operation after release, `0x00000001+0x00000001`, returns `0x00000002`.
- **Random regression:** 1000 random operations on both requesters with random `rsp_ready`. Required: every result equals `a+b+cin` (33 bits), response order matches accept order, and no handshake is lost.
